// File: rtl/sparse_a_result_serializer.sv
// Splits GF(2) result words from the sparse A-matrix multiplier into LSB-first beats and flags each frame's final beat.
// Optional SPARSE_A_SERIALIZER_CHECKSUM_EN appends one XOR-checksum beat per frame.
module sparse_a_result_serializer #(
  parameter int IN_WIDTH    = 96,
  parameter int OUT_WIDTH   = 8,
  parameter int FRAME_WORDS = 11
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [IN_WIDTH-1:0]  i_input_data,
  input  logic                 i_input_valid,
  output logic                 o_input_ready,
  output logic [OUT_WIDTH-1:0] o_output_data,
  output logic                 o_output_valid,
  output logic                 o_output_last,
  input  logic                 i_output_ready
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int WW    = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(FRAME_WORDS - 1);

  generate
    if ((IN_WIDTH % OUT_WIDTH) != 0 || FRAME_WORDS < 1) begin : g_bad_params
      $error("sparse_a_result_serializer: IN_WIDTH must be a multiple of OUT_WIDTH and FRAME_WORDS >= 1");
    end
  endgenerate

`ifdef SPARSE_A_SERIALIZER_CHECKSUM_EN
  typedef enum logic [1:0] {ST_EMPTY, ST_SHIFT, ST_CHECKSUM} state_t;
  logic [OUT_WIDTH-1:0] xor_q, xor_d;
`else
  typedef enum logic [1:0] {ST_EMPTY, ST_SHIFT} state_t;
`endif

  state_t               state_q, state_d;
  logic [IN_WIDTH-1:0]  shreg_q, shreg_d;
  logic [BW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [WW-1:0]        word_cnt_q, word_cnt_d;
  logic                 beat_last, word_last, in_ready, in_xfer, out_xfer;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    beat_cnt_d = beat_cnt_q;
    word_cnt_d = word_cnt_q;
`ifdef SPARSE_A_SERIALIZER_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    beat_last  = (beat_cnt_q == LAST_BEAT);
    word_last  = (word_cnt_q == LAST_WORD);
    out_xfer   = (state_q != ST_EMPTY) & i_output_ready;

    // The next word may load in the same cycle the current word's last beat leaves.
    in_ready = 1'b0;
    if (state_q == ST_EMPTY) begin
      in_ready = 1'b1;
    end else if (state_q == ST_SHIFT) begin
`ifdef SPARSE_A_SERIALIZER_CHECKSUM_EN
      in_ready = beat_last & i_output_ready & ~word_last;
`else
      in_ready = beat_last & i_output_ready;
`endif
    end
    in_xfer = i_input_valid & in_ready & ~i_reset;

    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          shreg_d    = i_input_data;
          beat_cnt_d = '0;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (out_xfer) begin
          shreg_d = shreg_q >> OUT_WIDTH;
`ifdef SPARSE_A_SERIALIZER_CHECKSUM_EN
          xor_d   = xor_q ^ shreg_q[OUT_WIDTH-1:0];
`endif
          if (beat_last) begin
            beat_cnt_d = '0;
            word_cnt_d = word_last ? '0 : word_cnt_q + 1'b1;
            if (in_xfer) begin
              shreg_d = i_input_data;
            end else begin
              state_d = ST_EMPTY;
            end
`ifdef SPARSE_A_SERIALIZER_CHECKSUM_EN
            if (word_last) begin
              state_d = ST_CHECKSUM;
            end
`endif
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
`ifdef SPARSE_A_SERIALIZER_CHECKSUM_EN
      ST_CHECKSUM: begin
        if (out_xfer) begin
          xor_d   = '0;
          state_d = ST_EMPTY;
        end
      end
`endif
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= ST_EMPTY;
      shreg_q    <= '0;
      beat_cnt_q <= '0;
      word_cnt_q <= '0;
`ifdef SPARSE_A_SERIALIZER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      beat_cnt_q <= beat_cnt_d;
      word_cnt_q <= word_cnt_d;
`ifdef SPARSE_A_SERIALIZER_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  assign o_input_ready  = in_ready & ~i_reset;
  assign o_output_valid = (state_q != ST_EMPTY);
`ifdef SPARSE_A_SERIALIZER_CHECKSUM_EN
  assign o_output_data  = (state_q == ST_CHECKSUM) ? xor_q : shreg_q[OUT_WIDTH-1:0];
  assign o_output_last  = (state_q == ST_CHECKSUM);
`else
  assign o_output_data  = shreg_q[OUT_WIDTH-1:0];
  assign o_output_last  = (state_q == ST_SHIFT) & beat_last & word_last;
`endif

endmodule

// File: tb/tb_sparse_a_result_serializer.sv
// Directed bench for sparse_a_result_serializer with a beat-queue reference model checked every cycle.
module tb_sparse_a_result_serializer;

`ifdef SPARSE_A_SERIALIZER_CHECKSUM_EN
  localparam int CKB = 1;
`else
  localparam int CKB = 0;
`endif
  localparam int FB = 132 + CKB;

  logic        i_clock;
  logic        i_reset;
  logic [95:0] i_input_data;
  logic        i_input_valid;
  logic        o_input_ready;
  logic [7:0]  o_output_data;
  logic        o_output_valid;
  logic        o_output_last;
  logic        i_output_ready;

  sparse_a_result_serializer dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_input_data   (i_input_data),
    .i_input_valid  (i_input_valid),
    .o_input_ready  (o_input_ready),
    .o_output_data  (o_output_data),
    .o_output_valid (o_output_valid),
    .o_output_last  (o_output_last),
    .i_output_ready (i_output_ready)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  typedef struct { logic [7:0] d; logic l; } beat_t;
  typedef struct { string name; int got; int exp; } chk_t;

  beat_t exp_q[$];
  chk_t  chk_q[$];
  int    beat_cyc_q[$];
  int    got_q[$];
  int    last_pos_q[$];
  int    total = 0, bad = 0, cyc = 0;
  int    beats_seen = 0, valid_cycles = 0, ready_pulses = 0;
  int    m_word = 0;
  logic [7:0] ck_x = '0;
  logic  toggle_en = 1'b0;

  always @(negedge i_clock) i_output_ready = toggle_en ? ~i_output_ready : 1'b1;

  // Single checker: drains queued scalar checks and compares every transferred beat against the model.
  always @(negedge i_clock) begin : compare
    chk_t  c;
    beat_t e;
    logic       prev_stall;
    logic [7:0] prev_d;
    logic       prev_l;
    #2;
    cyc++;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      total++;
      if (c.got != c.exp) begin
        bad++;
        $display("FAIL %s: got %0d expected %0d", c.name, c.got, c.exp);
      end
    end
    if (i_reset) begin
      prev_stall = 1'b0;
    end else begin
      if (o_output_valid) valid_cycles++;
      if (o_output_valid && o_input_ready) ready_pulses++;
      if (prev_stall && o_output_valid) begin
        total++;
        if (o_output_data !== prev_d || o_output_last !== prev_l) begin
          bad++;
          $display("FAIL hold: got data=%h last=%b expected data=%h last=%b", o_output_data, o_output_last, prev_d, prev_l);
        end
      end
      if (o_output_valid && i_output_ready) begin
        beats_seen++;
        beat_cyc_q.push_back(cyc);
        got_q.push_back(int'(o_output_data));
        if (o_output_last) last_pos_q.push_back(beats_seen);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_beat: got data=%h with no beat expected", o_output_data);
        end else begin
          e = exp_q.pop_front();
          if (o_output_data !== e.d || o_output_last !== e.l) begin
            bad++;
            $display("FAIL beat%0d: got data=%h last=%b expected data=%h last=%b", beats_seen, o_output_data, o_output_last, e.d, e.l);
          end
        end
      end
      prev_stall = o_output_valid & ~i_output_ready;
      prev_d = o_output_data;
      prev_l = o_output_last;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    chk_t c;
    c.name = nm; c.got = got; c.exp = exp;
    chk_q.push_back(c);
  endtask

  // Reference: every accepted word yields 12 LSB-first bytes; the 11th word of a frame closes it.
  task automatic push_word(input logic [95:0] w);
    beat_t b;
    for (int i = 0; i < 12; i++) begin
      b.d = w[i*8 +: 8];
      b.l = (m_word == 10 && i == 11 && CKB == 0);
      ck_x ^= b.d;
      exp_q.push_back(b);
    end
    if (m_word == 10) begin
      if (CKB == 1) begin
        b.d = ck_x; b.l = 1'b1;
        exp_q.push_back(b);
      end
      ck_x = '0;
      m_word = 0;
    end else begin
      m_word++;
    end
  endtask

  task automatic send_word(input logic [95:0] w);
    int   n = 0;
    logic acc = 1'b0;
    i_input_valid = 1'b1;
    i_input_data  = w;
    while (!acc && n < 400) begin
      #1;
      if (o_input_ready) acc = 1'b1;
      else begin
        @(negedge i_clock);
        n++;
      end
    end
    if (acc) begin
      push_word(w);
      @(negedge i_clock);
    end else begin
      chk("accept_timeout", 0, 1);
    end
  endtask

  task automatic drain();
    int n = 0;
    i_input_valid = 1'b0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(negedge i_clock);
      n++;
    end
    repeat (2) @(negedge i_clock);
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_input_valid = 1'b0;
    exp_q.delete();
    m_word = 0;
    ck_x = '0;
    repeat (3) @(negedge i_clock);
    #1;
    chk("rst_in_ready", int'(o_input_ready), 0);
    chk("rst_valid", int'(o_output_valid), 0);
    chk("rst_data", int'(o_output_data), 0);
    chk("rst_last", int'(o_output_last), 0);
    i_reset = 1'b0;
    #1;
    chk("post_rst_in_ready", int'(o_input_ready), 1);
  endtask

  logic [95:0] w_seq;
  logic [95:0] w_ones;
  int b0, v0, p0, l0, n;

  initial begin
    w_seq  = 96'h0C0B0A090807060504030201;
    w_ones = '1;
    i_reset = 1'b1;
    i_input_valid = 1'b0;
    i_input_data = '0;
    do_reset();

    // Idle with downstream ready.
    b0 = beats_seen; v0 = valid_cycles;
    repeat (100) @(negedge i_clock);
    chk("idle_beats", beats_seen - b0, 0);
    chk("idle_valid", valid_cycles - v0, 0);

    // One frame back-to-back at full throughput.
    b0 = beats_seen; p0 = ready_pulses; l0 = last_pos_q.size();
    for (int i = 0; i < 11; i++) send_word(w_seq);
    drain();
    chk("t2_beats", beats_seen - b0, FB);
    chk("t2_last_count", last_pos_q.size() - l0, 1);
    chk("t2_last_pos", last_pos_q[$] - b0, FB);
    chk("t2_no_gaps", beat_cyc_q[$] - beat_cyc_q[b0], FB - 1);
    chk("t2_first_beat", got_q[b0], 8'h01);
    chk("t2_beat132", got_q[b0 + 131], 8'h0C);
    if (CKB == 1) chk("t2_checksum", got_q[b0 + 132], 8'h0C);
    chk("t2_ready_pulses", ready_pulses - p0, 11 - CKB);

    // Same frame with downstream stalling every other cycle.
    b0 = beats_seen; l0 = last_pos_q.size();
    toggle_en = 1'b1;
    for (int i = 0; i < 11; i++) send_word(w_seq);
    drain();
    toggle_en = 1'b0;
    @(negedge i_clock);
    chk("t3_beats", beats_seen - b0, FB);
    chk("t3_last_pos", last_pos_q[$] - b0, FB);

    // Reset after five words plus three beats, then a clean frame.
    b0 = beats_seen;
    for (int i = 0; i < 6; i++) send_word(w_seq);
    i_input_valid = 1'b0;
    n = 0;
    while (beats_seen - b0 < 63 && n < 100) begin
      @(negedge i_clock);
      #3;
      n++;
    end
    chk("t4_reached_63", beats_seen - b0, 63);
    do_reset();
    @(negedge i_clock);
    b0 = beats_seen; l0 = last_pos_q.size();
    for (int i = 0; i < 11; i++) send_word(w_seq);
    drain();
    chk("t4_beats", beats_seen - b0, FB);
    chk("t4_first_beat", got_q[b0], 8'h01);
    chk("t4_last_count", last_pos_q.size() - l0, 1);
    chk("t4_last_pos", last_pos_q[$] - b0, FB);

    // Two frames: all-zero words then all-ones words.
    b0 = beats_seen; l0 = last_pos_q.size();
    for (int i = 0; i < 11; i++) send_word('0);
    for (int i = 0; i < 11; i++) send_word(w_ones);
    drain();
    chk("t5_beats", beats_seen - b0, 2 * FB);
    chk("t5_last_count", last_pos_q.size() - l0, 2);
    chk("t5_last_pos1", last_pos_q[l0] - b0, FB);
    chk("t5_last_pos2", last_pos_q[l0 + 1] - b0, 2 * FB);
    chk("t5_ones_beat", got_q[b0 + FB], 8'hFF);

    repeat (3) @(negedge i_clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
